// File: rtl/msrv32_lsu_pkg.sv
// Shared encodings for the sequential load/store unit.
package msrv32_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_DBL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/msrv32_lsu_align.sv
// Combinational lane steering: store data/strobe spread over two beats and
// load extract/extend from the merged beat pair.
module msrv32_lsu_align
    import msrv32_lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [$clog2(DATA_W/8)-1:0] off_in,
    input  logic [1:0]                  size_in,
    input  logic                        unsigned_in,
    input  logic [DATA_W-1:0]           wdata_in,
    input  logic [DATA_W-1:0]           beat0_in,
    input  logic [DATA_W-1:0]           beat1_in,
    output logic [2*DATA_W-1:0]         st_data_out,
    output logic [2*(DATA_W/8)-1:0]     st_strb_out,
    output logic [DATA_W-1:0]           ld_data_out
);

    localparam int B = DATA_W / 8;

    logic [3:0]          n_bytes;
    logic [2*DATA_W-1:0] merged;
    logic [DATA_W-1:0]   low;
    logic [DATA_W-1:0]   keep_mask;
    logic                sign_bit;

    // NOTE: every variable gets a value before any conditional use, so no latch is inferred.
    always_comb begin
        n_bytes     = 4'd1 << size_in;
        st_data_out = {{DATA_W{1'b0}}, wdata_in} << {off_in, 3'b000};
        for (int i = 0; i < 2 * B; i++) begin
            st_strb_out[i] = (i >= int'(off_in)) && (i < int'(off_in) + int'(n_bytes));
        end

        merged    = {beat1_in, beat0_in} >> {off_in, 3'b000};
        low       = merged[DATA_W-1:0];
        keep_mask = '0;
        sign_bit  = 1'b0;
        for (int i = 0; i < B; i++) begin
            keep_mask[8*i +: 8] = (i < int'(n_bytes)) ? 8'hFF : 8'h00;
            if (i == int'(n_bytes) - 1) begin
                sign_bit = low[8*i + 7];
            end
        end
        ld_data_out = (low & keep_mask) | ((!unsigned_in && sign_bit) ? ~keep_mask : '0);
    end

endmodule

// File: rtl/msrv32_lsu_misaligned.sv
// Sequential LSU: one request at a time, split into two bus beats when an
// access crosses a bus-word boundary (or trapped when splitting is disabled).
module msrv32_lsu_misaligned
    import msrv32_lsu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic                ms_riscv32_mp_clk_in,
    input  logic                ms_riscv32_mp_rst_n_in,
    input  logic                lsu_valid_in,
    output logic                lsu_ready_out,
    input  logic                lsu_we_in,
    input  logic [31:0]         lsu_addr_in,
    input  logic [1:0]          lsu_size_in,
    input  logic                lsu_unsigned_in,
    input  logic [DATA_W-1:0]   lsu_wdata_in,
    output logic                lsu_done_out,
    output logic [DATA_W-1:0]   lsu_rdata_out,
    output logic                lsu_err_out,
    output logic                misalign_out,
    output logic                dm_req_out,
    output logic [31:0]         dm_addr_out,
    output logic                dm_we_out,
    output logic [DATA_W/8-1:0] dm_wstrb_out,
    output logic [DATA_W-1:0]   dm_wdata_out,
    input  logic [DATA_W-1:0]   dm_rdata_in,
    input  logic                dm_ready_in,
    input  logic                dm_err_in
);

    localparam int B     = DATA_W / 8;
    localparam int OFF_W = $clog2(B);

    lsu_state_e        state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              we_q, we_d;
    logic              split_q, split_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] beat0_q, beat0_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              mis_q, mis_d;

    logic [1:0]         req_size;
    logic               req_split;
    logic [31:0]        beat_base;
    logic [DATA_W-1:0]  align_beat0;
    logic [DATA_W-1:0]  align_beat1;
    logic [2*DATA_W-1:0] st_data;
    logic [2*B-1:0]     st_strb;
    logic [DATA_W-1:0]  ld_data;

    // A double on a 32-bit bus degrades to a word access.
    assign req_size  = (DATA_W == 32 && lsu_size_in == SZ_DBL) ? SZ_WORD : lsu_size_in;
    assign req_split = (int'(lsu_addr_in[OFF_W-1:0]) + (1 << req_size)) > B;
    assign beat_base = addr_q & ~32'(B - 1);

    assign align_beat0 = (state_q == ACC0) ? dm_rdata_in : beat0_q;
    assign align_beat1 = (state_q == ACC1) ? dm_rdata_in : '0;

    msrv32_lsu_align #(.DATA_W(DATA_W)) u_align (
        .off_in      (addr_q[OFF_W-1:0]),
        .size_in     (size_q),
        .unsigned_in (uns_q),
        .wdata_in    (wdata_q),
        .beat0_in    (align_beat0),
        .beat1_in    (align_beat1),
        .st_data_out (st_data),
        .st_strb_out (st_strb),
        .ld_data_out (ld_data)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        uns_d        = uns_q;
        we_d         = we_q;
        split_d      = split_q;
        wdata_d      = wdata_q;
        beat0_d      = beat0_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        mis_d        = mis_q;
        dm_req_out   = 1'b0;
        dm_addr_out  = '0;
        dm_we_out    = 1'b0;
        dm_wstrb_out = '0;
        dm_wdata_out = '0;

        unique case (state_q)
            IDLE: begin
                if (lsu_valid_in) begin
                    addr_d  = lsu_addr_in;
                    size_d  = req_size;
                    uns_d   = lsu_unsigned_in;
                    we_d    = lsu_we_in;
                    split_d = req_split;
                    wdata_d = lsu_wdata_in;
                    if (req_split && !MISALIGN_EN) begin
                        state_d = RESP;
                        mis_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = ACC0;
                    end
                end
            end
            ACC0: begin
                dm_req_out   = 1'b1;
                dm_addr_out  = beat_base;
                dm_we_out    = we_q;
                dm_wstrb_out = we_q ? st_strb[B-1:0] : '0;
                dm_wdata_out = we_q ? st_data[DATA_W-1:0] : '0;
                if (dm_ready_in) begin
                    beat0_d = dm_rdata_in;
                    if (dm_err_in) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (split_q) begin
                        state_d = ACC1;
                    end else begin
                        state_d = RESP;
                        rdata_d = we_q ? '0 : ld_data;
                    end
                end
            end
            ACC1: begin
                dm_req_out   = 1'b1;
                dm_addr_out  = beat_base + 32'(B);
                dm_we_out    = we_q;
                dm_wstrb_out = we_q ? st_strb[2*B-1:B] : '0;
                dm_wdata_out = we_q ? st_data[2*DATA_W-1:DATA_W] : '0;
                if (dm_ready_in) begin
                    state_d = RESP;
                    err_d   = dm_err_in;
                    rdata_d = (we_q || dm_err_in) ? '0 : ld_data;
                end
            end
            RESP: begin
                // Results are cleared on exit so they read 0 outside the done pulse.
                state_d = IDLE;
                rdata_d = '0;
                err_d   = 1'b0;
                mis_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            split_q <= 1'b0;
            wdata_q <= '0;
            beat0_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            we_q    <= we_d;
            split_q <= split_d;
            wdata_q <= wdata_d;
            beat0_q <= beat0_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
        end
    end

    assign lsu_ready_out = (state_q == IDLE);
    assign lsu_done_out  = (state_q == RESP);
    assign lsu_rdata_out = rdata_q;
    assign lsu_err_out   = err_q;
    assign misalign_out  = mis_q;

endmodule
